// File: rtl/pulse_pkg.sv
// pulse_pkg: shared state encoding for the pulse generator / decoder pair.
package pulse_pkg;
    typedef enum logic [1:0] {PD_IDLE, PD_HIGH, PD_WAIT_LOW} pd_state_t;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registered previous sample of a synchronous input with rise/fall strobes.
module edge_detect (
    input  logic clk,
    input  logic i_reset_n,
    input  logic x,
    output logic rise,
    output logic fall
);
    logic prev;
    // Reset to 1 so an input already high at reset release does not look like a rising edge.
    always_ff @(posedge clk) begin
        if (!i_reset_n) prev <= 1'b1;
        else            prev <= x;
    end
    assign rise = x & ~prev;
    assign fall = ~x & prev;
endmodule

// File: rtl/pulse_width_decoder.sv
// pulse_width_decoder: measures input high time in clk cycles, valid/ready result.
// Optional `PULSE_WIDTH_DECODER_TIMEOUT_EN reports a timeout result as soon as MAX_WIDTH is exceeded.
module pulse_width_decoder
    import pulse_pkg::*;
#(
    parameter int MIN_WIDTH = 2,
    parameter int MAX_WIDTH = 255,
    localparam int CNT_W = $clog2(MAX_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic             i_x,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_width,
    output logic             o_timeout,
    output logic             o_glitch,
    output logic             o_overrun
);
    typedef struct packed {
        logic [CNT_W-1:0] width;
        logic             timeout;
    } result_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WIDTH);

    pd_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rise, fall, publish, glitch_nxt;
    result_t          res, res_nxt;

    edge_detect u_edge (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .x         (i_x),
        .rise      (rise),
        .fall      (fall)
    );

    // In HIGH and WAIT_LOW the previous sample is always 1, so fall is exactly i_x==0.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        publish    = 1'b0;
        glitch_nxt = 1'b0;
        res_nxt    = '{width: cnt, timeout: 1'b0};
        case (state)
            PD_IDLE: begin
                if (rise) begin
                    state_nxt = PD_HIGH;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            PD_HIGH: begin
                if (fall) begin
                    state_nxt  = PD_IDLE;
                    publish    = cnt >= MIN_CNT;
                    glitch_nxt = cnt < MIN_CNT;
                end
`ifdef PULSE_WIDTH_DECODER_TIMEOUT_EN
                else if (cnt == MAX_CNT) begin
                    state_nxt       = PD_WAIT_LOW;
                    publish         = 1'b1;
                    res_nxt.timeout = 1'b1;
                end
`endif
                else if (cnt != MAX_CNT) cnt_nxt = cnt + 1'b1;
            end
            PD_WAIT_LOW: begin
                if (fall) state_nxt = PD_IDLE;
            end
            default: state_nxt = PD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state <= PD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A publish blocked by an unaccepted result is dropped and flagged; acceptance frees the slot same cycle.
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            o_valid   <= 1'b0;
            res       <= '0;
            o_glitch  <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_glitch  <= glitch_nxt;
            o_overrun <= publish && o_valid && !i_ready;
            if (publish && (!o_valid || i_ready)) begin
                o_valid <= 1'b1;
                res     <= res_nxt;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_width   = res.width;
    assign o_timeout = res.timeout;
endmodule

// File: tb/tb_pulse_width_decoder.sv
// tb_pulse_width_decoder: directed scenarios plus random pulse trains against a run-length model.
module tb_pulse_width_decoder;
    localparam int MIN = 2;
    localparam int MAX = 10;
    localparam int W = $clog2(MAX + 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         x = 1'b0;
    logic         rdy = 1'b1;
    logic         valid, tmo, glitch, overrun;
    logic [W-1:0] width;

    int vectors = 0;
    int errors = 0;

    // Model state: run length of the current high stretch, and the pending result slot.
    bit m_armed, m_to_done, m_valid, m_to, m_gl, m_ov;
    int m_run, m_width;

    always #5 clk = ~clk;

    pulse_width_decoder #(.MIN_WIDTH(MIN), .MAX_WIDTH(MAX)) dut (
        .clk       (clk),
        .i_reset_n (rst_n),
        .i_x       (x),
        .i_ready   (rdy),
        .o_valid   (valid),
        .o_width   (width),
        .o_timeout (tmo),
        .o_glitch  (glitch),
        .o_overrun (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pub = 0;
        bit pto = 0;
        int pw = 0;
        if (!rst_n) begin
            m_armed = 0; m_run = 0; m_to_done = 0;
            m_valid = 0; m_width = 0; m_to = 0; m_gl = 0; m_ov = 0;
            return;
        end
        m_gl = 0;
        m_ov = 0;
        if (x) begin
            if (m_armed) begin
                m_run++;
`ifdef PULSE_WIDTH_DECODER_TIMEOUT_EN
                if (m_run == MAX + 1) begin
                    pub = 1; pw = MAX; pto = 1; m_to_done = 1;
                end
`endif
            end
        end else begin
            if (m_run > 0 && !m_to_done) begin
                pw = (m_run < MAX) ? m_run : MAX;
                if (pw >= MIN) pub = 1;
                else m_gl = 1;
            end
            m_run = 0;
            m_to_done = 0;
            m_armed = 1;
        end
        if (pub) begin
            if (m_valid && !rdy) m_ov = 1;
            else begin
                m_valid = 1; m_width = pw; m_to = pto;
            end
        end else if (m_valid && rdy) m_valid = 0;
    endtask

    task automatic step(input logic nx, input logic nr, input logic nrst = 1'b1);
        @(negedge clk);
        x = nx;
        rdy = nr;
        rst_n = nrst;
        @(posedge clk);
        model_step();
        #1;
        chk("valid", 32'(valid), 32'(m_valid));
        chk("width", 32'(width), 32'(m_width));
        chk("timeout", 32'(tmo), 32'(m_to));
        chk("glitch", 32'(glitch), 32'(m_gl));
        chk("overrun", 32'(overrun), 32'(m_ov));
    endtask

    task automatic pulse(input int hi, input int lo, input logic r = 1'b1);
        repeat (hi) step(1'b1, r);
        repeat (lo) step(1'b0, r);
    endtask

    initial begin
        repeat (2) step(1'b0, 1'b1, 1'b0);
        chk("reset_valid", 32'(valid), 0);
        step(1'b0, 1'b1);
        pulse(5, 1);
        chk("t1_valid", 32'(valid), 1);
        chk("t1_width", 32'(width), 5);
        step(1'b0, 1'b1);
        chk("t1_drop", 32'(valid), 0);
        pulse(1, 1);
        chk("t2_glitch", 32'(glitch), 1);
        chk("t2_no_valid", 32'(valid), 0);
        pulse(2, 1);
        chk("t2_width", 32'(width), 2);
        step(1'b0, 1'b1);
        pulse(4, 2, 1'b0);
        pulse(6, 1, 1'b0);
        chk("t3_overrun", 32'(overrun), 1);
        chk("t3_held", 32'(width), 4);
        step(1'b0, 1'b1);
        chk("t3_accept", 32'(valid), 0);
        pulse(15, 1);
        chk("t4_width", 32'(width), MAX);
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("t5_valid", 32'(valid), 0);
        chk("t5_width", 32'(width), 0);
        repeat (2) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("t5_no_result", 32'(valid), 0);
        pulse(3, 1);
        chk("t5_width3", 32'(width), 3);
        step(1'b0, 1'b1);
        pulse(3, 1);
        chk("t6_first", 32'(width), 3);
        pulse(4, 1);
        chk("t6_second", 32'(width), 4);
        chk("t6_no_overrun", 32'(overrun), 0);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 40) == 0) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            pulse($urandom_range(1, 14), $urandom_range(1, 3), 1'($urandom_range(0, 3) != 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
